// File: rtl/hazard_forward_unit_if.sv
// Decode-stage hazard/forwarding bus between the pipeline control and
// hazard_forward_unit. The pipeline (master) presents the decode instruction
// and the global freeze/flush controls; the unit (slave) returns stall,
// operand-forward selects and the mul-div busy flag.
//
// Handshake: the decode instruction is offered while id_valid=1 and is
// accepted into the tracker on a rising clk edge only when id_valid=1,
// stall=0, flush=0 and freeze=0. stall acts as the inverted ready; the
// master must hold the decode fields stable while stall=1 (or freeze=1).
interface hazard_forward_unit_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FWD_DEPTH      = 3
) ();
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);

    logic                      id_valid;
    logic [REG_ADDR_WIDTH-1:0] id_rs;
    logic [REG_ADDR_WIDTH-1:0] id_rt;
    logic                      id_uses_rs;
    logic                      id_uses_rt;
    logic                      id_wreg;
    logic [REG_ADDR_WIDTH-1:0] id_dest;
    logic                      id_is_load;
    logic                      id_is_muldiv;
    logic                      freeze;
    logic                      flush;

    logic                      stall;
    logic [SEL_W-1:0]          fwd_rs;
    logic [SEL_W-1:0]          fwd_rt;
    logic                      muldiv_busy;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_wreg, id_dest, id_is_load, id_is_muldiv, freeze, flush,
        input  stall, fwd_rs, fwd_rt, muldiv_busy
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_wreg, id_dest, id_is_load, id_is_muldiv, freeze, flush,
        output stall, fwd_rs, fwd_rt, muldiv_busy
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand-forward selection for an in-order pipeline.
// A small shift-register tracker remembers the destination of the last
// FWD_DEPTH issued instructions (entry 1 = issued last cycle). Decode
// sources are matched against it to pick the youngest producer; a long
// producer (load or mul-div) still in entry 1 forces a one-cycle stall, and
// a mul-div occupancy counter stalls every decode instruction while busy.
module hazard_forward_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FWD_DEPTH      = 3,
    parameter int MULDIV_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_forward_unit_if.slave  bus
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);
    // At least 3 bits, wider only when the occupancy needs it.
    localparam int CNT_W = (MULDIV_CYCLES > 8) ? $clog2(MULDIV_CYCLES) : 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    // Tracker state, index 1 is the youngest entry.
    logic [FWD_DEPTH:1]        trk_valid_q, trk_valid_d;
    logic [FWD_DEPTH:1]        trk_wreg_q,  trk_wreg_d;
    logic [FWD_DEPTH:1]        trk_long_q,  trk_long_d;
    logic [REG_ADDR_WIDTH-1:0] trk_dest_q [1:FWD_DEPTH];
    logic [REG_ADDR_WIDTH-1:0] trk_dest_d [1:FWD_DEPTH];

    // Remaining mul-div occupancy after the issue cycle.
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic [SEL_W-1:0]          fwd_rs_sel;
    logic [SEL_W-1:0]          fwd_rt_sel;
    logic                      rs_long_hit;
    logic                      rt_long_hit;
    logic                      busy;
    logic                      stall_int;
    logic                      issue;

    // Youngest-producer search: scan oldest to youngest so the smallest
    // matching index wins. Register 0 and unused sources never match.
    always_comb begin
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (trk_valid_q[k] && trk_wreg_q[k] && bus.id_uses_rs &&
                (bus.id_rs != '0) && (trk_dest_q[k] == bus.id_rs)) begin
                fwd_rs_sel = SEL_W'(k);
            end
            if (trk_valid_q[k] && trk_wreg_q[k] && bus.id_uses_rt &&
                (bus.id_rt != '0) && (trk_dest_q[k] == bus.id_rt)) begin
                fwd_rt_sel = SEL_W'(k);
            end
        end
    end

    // Stall when a long producer sits in entry 1 or the mul-div unit is busy.
    always_comb begin
        rs_long_hit = (fwd_rs_sel == SEL_W'(1)) && trk_long_q[1];
        rt_long_hit = (fwd_rt_sel == SEL_W'(1)) && trk_long_q[1];
        busy        = (cnt_q != '0);
        stall_int   = bus.id_valid && (rs_long_hit || rt_long_hit || busy);
        // flush kills the decode instruction even when stall is also raised.
        issue       = bus.id_valid && !stall_int && !bus.flush;
    end

    // Tracker shift and counter update; everything holds while frozen.
    always_comb begin
        trk_valid_d = trk_valid_q;
        trk_wreg_d  = trk_wreg_q;
        trk_long_d  = trk_long_q;
        trk_dest_d  = trk_dest_q;
        cnt_d       = cnt_q;
        if (!bus.freeze) begin
            for (int k = FWD_DEPTH; k >= 2; k--) begin
                trk_valid_d[k] = trk_valid_q[k-1];
                trk_wreg_d[k]  = trk_wreg_q[k-1];
                trk_long_d[k]  = trk_long_q[k-1];
                trk_dest_d[k]  = trk_dest_q[k-1];
            end
            if (issue) begin
                trk_valid_d[1] = 1'b1;
                trk_wreg_d[1]  = bus.id_wreg;
                trk_long_d[1]  = bus.id_is_load || bus.id_is_muldiv;
                trk_dest_d[1]  = bus.id_dest;
            end else begin
                trk_valid_d[1] = 1'b0;
                trk_wreg_d[1]  = 1'b0;
                trk_long_d[1]  = 1'b0;
                trk_dest_d[1]  = '0;
            end
            if (issue && bus.id_is_muldiv) begin
                cnt_d = CNT_LOAD;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // State registers; reset overrides freeze and any running mul-div.
    always_ff @(posedge clk) begin
        if (rst) begin
            trk_valid_q <= '0;
            trk_wreg_q  <= '0;
            trk_long_q  <= '0;
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                trk_dest_q[k] <= '0;
            end
            cnt_q       <= '0;
        end else begin
            trk_valid_q <= trk_valid_d;
            trk_wreg_q  <= trk_wreg_d;
            trk_long_q  <= trk_long_d;
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                trk_dest_q[k] <= trk_dest_d[k];
            end
            cnt_q       <= cnt_d;
        end
    end

    // Outputs are same-cycle functions of held state and decode inputs.
    always_comb begin
        bus.stall       = stall_int;
        bus.fwd_rs      = fwd_rs_sel;
        bus.fwd_rt      = fwd_rt_sel;
        bus.muldiv_busy = busy;
    end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Testbench for hazard_forward_unit: directed pipeline scenarios plus a
// randomized producer/consumer distance sweep. A second instance with
// MULDIV_CYCLES=1 shares the inputs and must never report busy.
module tb_hazard_forward_unit;
    localparam int RW    = 5;
    localparam int FD    = 3;
    localparam int MC    = 4;
    localparam int SEL_W = $clog2(FD + 1);
    localparam int W     = 2 * SEL_W + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_forward_unit_if #(.REG_ADDR_WIDTH(RW), .FWD_DEPTH(FD)) bus0 ();
    hazard_forward_unit_if #(.REG_ADDR_WIDTH(RW), .FWD_DEPTH(FD)) bus1 ();

    hazard_forward_unit #(.REG_ADDR_WIDTH(RW), .FWD_DEPTH(FD), .MULDIV_CYCLES(MC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    hazard_forward_unit #(.REG_ADDR_WIDTH(RW), .FWD_DEPTH(FD), .MULDIV_CYCLES(1)) dut_mc1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    assign bus1.id_valid     = bus0.id_valid;
    assign bus1.id_rs        = bus0.id_rs;
    assign bus1.id_rt        = bus0.id_rt;
    assign bus1.id_uses_rs   = bus0.id_uses_rs;
    assign bus1.id_uses_rt   = bus0.id_uses_rt;
    assign bus1.id_wreg      = bus0.id_wreg;
    assign bus1.id_dest      = bus0.id_dest;
    assign bus1.id_is_load   = bus0.id_is_load;
    assign bus1.id_is_muldiv = bus0.id_is_muldiv;
    assign bus1.freeze       = bus0.freeze;
    assign bus1.flush        = bus0.flush;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    bit           chk_mc1  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected output word is {stall, fwd_rs, fwd_rt, muldiv_busy}.
    task automatic expect_out(input logic s, input int frs, input int frt, input logic b,
                              input string tag);
        exp_q.push_back({s, SEL_W'(frs), SEL_W'(frt), b});
        tag_q.push_back(tag);
    endtask

    // Compare on the falling edge, then advance past the next rising edge.
    task automatic tick();
        logic [W-1:0] got;
        logic [W-1:0] e;
        string        t;
        @(negedge clk);
        got = {bus0.stall, bus0.fwd_rs, bus0.fwd_rt, bus0.muldiv_busy};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_eq(t, 32'(got), 32'(e));
        end
        if (chk_mc1) check_eq("mc1_busy", 32'(bus1.muldiv_busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        bus0.id_valid     = 1'b0;
        bus0.id_rs        = '0;
        bus0.id_rt        = '0;
        bus0.id_uses_rs   = 1'b0;
        bus0.id_uses_rt   = 1'b0;
        bus0.id_wreg      = 1'b0;
        bus0.id_dest      = '0;
        bus0.id_is_load   = 1'b0;
        bus0.id_is_muldiv = 1'b0;
    endtask

    task automatic set_instr(input int rs, input int rt, input logic urs, input logic urt,
                             input logic wreg, input int dest, input logic ld, input logic md);
        bus0.id_valid     = 1'b1;
        bus0.id_rs        = RW'(rs);
        bus0.id_rt        = RW'(rt);
        bus0.id_uses_rs   = urs;
        bus0.id_uses_rt   = urt;
        bus0.id_wreg      = wreg;
        bus0.id_dest      = RW'(dest);
        bus0.id_is_load   = ld;
        bus0.id_is_muldiv = md;
    endtask

    task automatic drain();
        set_idle();
        repeat (FD) begin
            expect_out(0, 0, 0, 0, "drain");
            tick();
        end
    endtask

    // ---------------- stimulus ----------------
    int r, o, d;
    bit is_ld, on_rs;

    initial begin
        rst         = 1'b1;
        bus0.freeze = 1'b0;
        bus0.flush  = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        chk_mc1 = 1'b1;

        expect_out(0, 0, 0, 0, "reset_idle");
        tick();

        // lw $8 then add $9,$8,$1: one stall cycle, then forward from entry 2.
        set_instr(2, 0, 1, 0, 1, 8, 1, 0);
        expect_out(0, 0, 0, 0, "ldu_issue");
        tick();
        set_instr(8, 1, 1, 1, 1, 9, 0, 0);
        expect_out(1, 1, 0, 0, "ldu_stall");
        tick();
        expect_out(0, 2, 0, 0, "ldu_fwd2");
        tick();
        drain();

        // add $3 then sub $4,$3,$3, then another reader of $3.
        set_instr(1, 2, 1, 1, 1, 3, 0, 0);
        expect_out(0, 0, 0, 0, "alu_issue");
        tick();
        set_instr(3, 3, 1, 1, 1, 4, 0, 0);
        expect_out(0, 1, 1, 0, "alu_fwd1");
        tick();
        set_instr(3, 3, 1, 1, 1, 6, 0, 0);
        expect_out(0, 2, 2, 0, "alu_fwd2");
        tick();
        drain();

        // Writes to $0 never forward.
        set_instr(1, 2, 1, 1, 1, 0, 0, 0);
        expect_out(0, 0, 0, 0, "r0_write");
        tick();
        set_instr(0, 0, 1, 1, 1, 7, 0, 0);
        expect_out(0, 0, 0, 0, "r0_read");
        tick();
        drain();

        // Two writes to $5: youngest producer wins.
        set_instr(1, 2, 1, 1, 1, 5, 0, 0);
        expect_out(0, 0, 0, 0, "r5_w1");
        tick();
        set_instr(1, 2, 1, 1, 1, 5, 0, 0);
        expect_out(0, 0, 0, 0, "r5_w2");
        tick();
        set_instr(5, 0, 1, 1, 0, 0, 0, 0);
        expect_out(0, 1, 0, 0, "r5_youngest");
        tick();
        drain();

        // Uses flags gate matching.
        set_instr(0, 0, 0, 0, 1, 21, 0, 0);
        expect_out(0, 0, 0, 0, "uses_prod");
        tick();
        set_instr(21, 21, 0, 1, 0, 0, 0, 0);
        expect_out(0, 0, 1, 0, "uses_gate");
        tick();
        drain();

        // Producer at the oldest entry forwards, then retires.
        set_instr(0, 0, 0, 0, 1, 7, 0, 0);
        expect_out(0, 0, 0, 0, "ret_prod");
        tick();
        set_idle();
        repeat (FD - 1) begin
            expect_out(0, 0, 0, 0, "ret_gap");
            tick();
        end
        set_instr(7, 0, 1, 0, 0, 0, 0, 0);
        expect_out(0, FD, 0, 0, "ret_last");
        tick();
        expect_out(0, 0, 0, 0, "ret_gone");
        tick();
        drain();

        // Freeze holds the tracker in place.
        set_instr(0, 0, 0, 0, 1, 20, 0, 0);
        expect_out(0, 0, 0, 0, "frz_prod");
        tick();
        set_instr(20, 0, 1, 0, 0, 0, 0, 0);
        bus0.freeze = 1'b1;
        repeat (2) begin
            expect_out(0, 1, 0, 0, "frz_hold");
            tick();
        end
        bus0.freeze = 1'b0;
        expect_out(0, 1, 0, 0, "frz_rel");
        tick();
        expect_out(0, 2, 0, 0, "frz_age");
        tick();
        drain();

        // Mul-div occupancy with decode held valid.
        set_instr(1, 2, 1, 1, 0, 0, 0, 1);
        expect_out(0, 0, 0, 0, "md_issue");
        tick();
        set_instr(10, 11, 1, 1, 1, 12, 0, 0);
        repeat (MC - 1) begin
            expect_out(1, 0, 0, 1, "md_busy");
            tick();
        end
        expect_out(0, 0, 0, 0, "md_done");
        tick();
        drain();

        // Mul-div with two frozen cycles stretches busy to MC+1 cycles.
        set_instr(1, 2, 1, 1, 0, 0, 0, 1);
        expect_out(0, 0, 0, 0, "mdf_issue");
        tick();
        set_instr(10, 11, 1, 1, 1, 12, 0, 0);
        bus0.freeze = 1'b1;
        repeat (2) begin
            expect_out(1, 0, 0, 1, "mdf_frozen");
            tick();
        end
        bus0.freeze = 1'b0;
        repeat (MC - 1) begin
            expect_out(1, 0, 0, 1, "mdf_busy");
            tick();
        end
        expect_out(0, 0, 0, 0, "mdf_done");
        tick();
        drain();

        // Flush during a load-use stall.
        set_instr(2, 0, 1, 0, 1, 8, 1, 0);
        expect_out(0, 0, 0, 0, "fl_ld");
        tick();
        set_instr(8, 1, 1, 1, 1, 9, 0, 0);
        bus0.flush = 1'b1;
        expect_out(1, 1, 0, 0, "fl_ldu_stall");
        tick();
        bus0.flush = 1'b0;
        set_instr(9, 8, 1, 1, 1, 10, 0, 0);
        expect_out(0, 0, 2, 0, "fl_ldu_next");
        tick();
        drain();

        // Flush of an otherwise-issuing instruction.
        set_instr(1, 2, 1, 1, 1, 11, 0, 0);
        bus0.flush = 1'b1;
        expect_out(0, 0, 0, 0, "fl_alu");
        tick();
        bus0.flush = 1'b0;
        set_instr(11, 0, 1, 0, 0, 0, 0, 0);
        expect_out(0, 0, 0, 0, "fl_kill");
        tick();
        drain();

        // Flush suppresses the mul-div counter load.
        set_instr(1, 2, 1, 1, 0, 0, 0, 1);
        bus0.flush = 1'b1;
        expect_out(0, 0, 0, 0, "fl_md");
        tick();
        bus0.flush = 1'b0;
        set_instr(10, 11, 1, 1, 0, 0, 0, 0);
        expect_out(0, 0, 0, 0, "fl_md_next");
        tick();
        drain();

        // Reset in the middle of a mul-div, overriding freeze.
        set_instr(1, 2, 1, 1, 1, 13, 0, 1);
        expect_out(0, 0, 0, 0, "rst_md_issue");
        tick();
        set_instr(13, 0, 1, 0, 0, 0, 0, 0);
        expect_out(1, 1, 0, 1, "rst_md_c1");
        tick();
        rst         = 1'b1;
        bus0.freeze = 1'b1;
        expect_out(1, 2, 0, 1, "rst_md_c2");
        tick();
        rst         = 1'b0;
        bus0.freeze = 1'b0;
        expect_out(0, 0, 0, 0, "rst_md_after");
        tick();
        drain();

        // Random producer/consumer distance sweep.
        for (int i = 0; i < 10; i++) begin
            r     = $urandom_range(1, 31);
            o     = $urandom_range(1, 31);
            if (o == r) o = (r % 31) + 1;
            d     = $urandom_range(1, FD + 1);
            is_ld = 1'($urandom_range(0, 1));
            on_rs = 1'($urandom_range(0, 1));
            set_instr(0, 0, 0, 0, 1, r, is_ld, 0);
            expect_out(0, 0, 0, 0, "rnd_prod");
            tick();
            set_idle();
            repeat (d - 1) begin
                expect_out(0, 0, 0, 0, "rnd_gap");
                tick();
            end
            if (on_rs) set_instr(r, o, 1, 1, 0, 0, 0, 0);
            else       set_instr(o, r, 1, 1, 0, 0, 0, 0);
            if (is_ld && d == 1) begin
                expect_out(1, on_rs ? 1 : 0, on_rs ? 0 : 1, 0, "rnd_ldu_stall");
                tick();
                expect_out(0, on_rs ? 2 : 0, on_rs ? 0 : 2, 0, "rnd_ldu_fwd");
                tick();
            end else begin
                expect_out(0, (on_rs && d <= FD) ? d : 0, (!on_rs && d <= FD) ? d : 0, 0,
                           "rnd_fwd");
                tick();
            end
            drain();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog: the sequence is fixed-length, so this only fires on a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 The block SHALL have parameter REG_ADDR_WIDTH, default 5, meaning register-specifier width.
REQ-002 The block SHALL have parameter FWD_DEPTH, default 3, meaning tracked in-flight stages (1=EX, 2=MEM, 3=WB); legal range 1..7.
REQ-003 The block SHALL have parameter MULDIV_CYCLES, default 4, meaning multiply/divide occupancy in cycles; legal range >=1.
REQ-004 The block SHALL derive SEL_W = $clog2(FWD_DEPTH+1) as the forward-select width.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 id_valid  in  1  decode stage holds a real instruction.
REQ-008 id_rs, id_rt  in  REG_ADDR_WIDTH  decode source specifiers.
REQ-009 id_uses_rs, id_uses_rt  in  1  decode instruction reads rs / rt.
REQ-010 id_wreg, id_dest  in  1, REG_ADDR_WIDTH  decode instruction writes register id_dest.
REQ-011 id_is_load, id_is_muldiv  in  1  decode instruction is a load / multi-cycle mul-div.
REQ-012 freeze  in  1  external memory stall; all state holds.
REQ-013 flush  in  1  taken branch/jump; decode instruction is killed.
REQ-014 stall  out  1  hold PC and IF/ID, insert bubble into EX.
REQ-015 fwd_rs, fwd_rt  out  SEL_W  operand source: 0=register file, k=tracker entry k.
REQ-016 muldiv_busy  out  1  mul-div unit occupied.

Function
REQ-017 The block SHALL keep a tracker of FWD_DEPTH entries {valid, wreg, dest, is_long}; entry 1 = instruction issued in the previous cycle, entry k ages to k+1, entry FWD_DEPTH retires.
REQ-018 On each clk edge with freeze=0, the tracker SHALL shift by one and entry 1 SHALL load the decode instruction (is_long = id_is_load|id_is_muldiv) iff id_valid & !stall & !flush, otherwise a bubble (valid=0).
REQ-019 With freeze=1 the tracker and mul-div counter SHALL hold; stall and fwd outputs remain combinational from held state.
REQ-020 Entry k SHALL match source s iff valid & wreg & dest==s & s!=0 & the corresponding id_uses_* is 1.
REQ-021 fwd_rs/fwd_rt SHALL be the smallest matching k (youngest producer), else 0; register 0 always yields 0.
REQ-022 Load-use: stall SHALL be 1 when id_valid and the youngest match for rs or rt is entry 1 with is_long=1; matches at entry >=2 forward without stall.
REQ-023 A 3-bit-wide-enough counter SHALL load MULDIV_CYCLES-1 when a mul-div issues into entry 1 and decrement by 1 per non-frozen cycle, saturating at 0.
REQ-024 muldiv_busy SHALL equal (counter != 0); while busy, stall SHALL be 1 whenever id_valid=1.
REQ-025 MULDIV_CYCLES=1 SHALL never assert muldiv_busy.
REQ-026 flush=1 SHALL force a bubble into entry 1 and suppress counter load, taking priority over stall; stall output itself is still reported.
REQ-027 stall, fwd_rs, fwd_rt SHALL be combinational (same-cycle) from tracker, counter and decode inputs; no added latency.
REQ-028 With id_valid=0, stall SHALL be 0 and no counter load SHALL occur.

Reset
REQ-029 While rst=1 at a clk edge, all tracker entries SHALL become invalid and counter 0, overriding freeze and any in-progress mul-div.
REQ-030 After reset, with id_valid=0: stall=0, fwd_rs=0, fwd_rt=0, muldiv_busy=0.

Verification
REQ-031 Issue lw $8, then add $9,$8,$1 -> stall=1 for exactly 1 cycle, then fwd_rs=2, fwd_rt=0, stall=0.
REQ-032 Issue add $3,..., then sub $4,$3,$3 -> fwd_rs=1, fwd_rt=1, stall=0; one cycle later with same sources -> both 2.
REQ-033 Issue write to $0, then read $0 -> fwd_rs=0, stall=0; two consecutive writes to $5 then read $5 -> fwd_rs=1.
REQ-034 MULDIV_CYCLES=4: issue mul-div, hold id_valid=1 -> muldiv_busy=1 and stall=1 for 3 cycles, then both 0; freeze=1 for 2 of those cycles extends busy to 5 cycles.
REQ-035 flush=1 in same cycle as a load-use stall -> entry 1 bubble, next cycle fwd_rs=0 for that source.
REQ-036 rst=1 mid mul-div (counter=2) -> next cycle muldiv_busy=0, stall=0, all fwd=0.
